// File: rtl/mul_lane_array_pipe.sv
// Per-lane signed multiply, rounded arithmetic right shift, optional saturation; 2-cycle latency, 1 beat/cycle.
// Backpressure: out stage holds while out_valid & !out_ready; in_ready drops only when both stages are full and stalled.
module mul_lane_array_pipe #(
    parameter int WIDTH = 32,
    parameter int LANES = 16,
    parameter int SHW   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   sel_in,
    input  logic [SHW-1:0]         shift_right,
    input  logic                   sat_en,
    input  logic [LANES*WIDTH-1:0] hot_in,
    input  logic [LANES*WIDTH-1:0] cold_in,
    input  logic [LANES*WIDTH-1:0] pre_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out,
    output logic [LANES-1:0]       ovf
);
    localparam int PW = 2 * WIDTH;
    localparam int RW = PW + 1;

    typedef struct packed {
        logic [SHW-1:0] sh;
        logic           sat;
    } meta_t;

    logic                   s1_vld_q, s1_vld_d;
    meta_t                  s1_meta_q, s1_meta_d;
    logic [LANES*PW-1:0]    s1_prod_q, s1_prod_d;
    logic                   out_vld_q, out_vld_d;
    logic [LANES*WIDTH-1:0] out_q, out_d;
    logic [LANES-1:0]       ovf_q, ovf_d;
    logic                   s2_adv, s1_adv, in_acc;

    function automatic logic [PW-1:0] lane_mul(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic signed [PW-1:0] ax;
        logic signed [PW-1:0] bx;
        ax = {{WIDTH{a[WIDTH-1]}}, a};
        bx = {{WIDTH{b[WIDTH-1]}}, b};
        return ax * bx;
    endfunction

    // Returns {ovf, result}; one extra bit keeps P + rounding constant from overflowing.
    function automatic logic [WIDTH:0] lane_post(input logic [PW-1:0] p, input meta_t m);
        logic signed [RW-1:0] px;
        logic signed [RW-1:0] rnd;
        logic signed [RW-1:0] r;
        logic [RW-WIDTH:0]    hi;
        logic                 v;
        logic [WIDTH-1:0]     res;
        px  = {p[PW-1], p};
        rnd = '0;
        if (int'(m.sh) >= PW - 1) begin
            r = {RW{p[PW-1]}};
        end else begin
            if (m.sh != '0) begin
                rnd = RW'(1) << (m.sh - SHW'(1));
            end
            r = (px + rnd) >>> m.sh;
        end
        hi = r[RW-1:WIDTH-1];
        v  = !((&hi) || !(|hi));
        if (v && m.sat) begin
            res = r[RW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res = r[WIDTH-1:0];
        end
        return {v, res};
    endfunction

    assign s2_adv   = !out_vld_q || out_ready;
    // An empty s2 always advances, so s1 can simply follow s2.
    assign s1_adv   = s2_adv;
    assign in_ready = !s1_vld_q || s1_adv;
    assign in_acc   = in_valid && in_ready;

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_meta_d = s1_meta_q;
        s1_prod_d = s1_prod_q;
        if (in_ready) begin
            s1_vld_d = in_valid;
        end
        if (in_acc) begin
            s1_meta_d = '{sh: shift_right, sat: sat_en};
            for (int i = 0; i < LANES; i++) begin
                s1_prod_d[i*PW +: PW] = sel_in ?
                    lane_mul(hot_in[i*WIDTH +: WIDTH], cold_in[i*WIDTH +: WIDTH]) :
                    lane_mul(pre_data[i*WIDTH +: WIDTH], pre_data[i*WIDTH +: WIDTH]);
            end
        end
    end

    always_comb begin
        logic [WIDTH:0] post;
        post      = '0;
        out_vld_d = out_vld_q;
        out_d     = out_q;
        ovf_d     = ovf_q;
        if (s2_adv) begin
            out_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                for (int i = 0; i < LANES; i++) begin
                    post                     = lane_post(s1_prod_q[i*PW +: PW], s1_meta_q);
                    ovf_d[i]                 = post[WIDTH];
                    out_d[i*WIDTH +: WIDTH]  = post[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_meta_q <= '0;
            s1_prod_q <= '0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
            ovf_q     <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_meta_q <= s1_meta_d;
            s1_prod_q <= s1_prod_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out       = out_q;
    assign ovf       = ovf_q;

endmodule
